vec_resp_checker: RTL and testbench

- Consumer end of the trojan-detection vector stream: accepts (input vector, DUT response) pairs and compares each against a golden truth table.
- Counts mismatches, records the first failing vector, and tracks which vectors were exercised.
- Sits after the stimulus/response capture stage; gives a synthesizable pass/fail verdict per benchmark run.

---
 rtl/vec_resp_checker_if.sv | 27 ++
 rtl/vec_resp_checker.sv | 138 +++++++++++++
 tb/tb_vec_resp_checker.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_resp_checker_if.sv
// Vector/response stream bundle into the trojan-detection checker.
// The stimulus side uses master; vec_resp_checker uses slave.
interface vec_resp_checker_if #(
    parameter int N_IN = 2
);
    logic            s_valid;
    logic            s_ready;
    logic [N_IN-1:0] s_vec;
    logic            s_resp;
    logic            s_last;

    modport master (
        output s_valid,
        output s_vec,
        output s_resp,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_vec,
        input  s_resp,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/vec_resp_checker.sv
// Compares streamed (vector, response) pairs against a golden truth table and gives a pass/fail verdict.
// Optional VRC_STOP_ON_FAIL_EN: the first mismatch ends the run early.
module vec_resp_checker #(
    parameter int N_IN  = 2,
    parameter int CNT_W = N_IN + 2
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [N_IN-1:0]      cfg_addr,
    input  logic                 cfg_data,
    input  logic                 start,
    vec_resp_checker_if.slave    s_if,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     mismatch_cnt,
    output logic                 first_fail_valid,
    output logic [N_IN-1:0]      first_fail_vec,
    output logic [2**N_IN-1:0]   coverage
);
    localparam int DEPTH = 2**N_IN;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DEPTH-1:0] golden;

    logic             clear_p0;
    logic             vld_p0;
    logic             mism_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic [DEPTH-1:0] cov_p0;
    logic             pass_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Stage p0: transfer decode, compare against golden, next-state
    always_comb begin
        state_nxt   = state;
        s_if.s_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        clear_p0    = 1'b0;
        vld_p0      = 1'b0;
        mism_p0     = 1'b0;
        cnt_p0      = mismatch_cnt;
        cov_p0      = coverage;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    clear_p0  = 1'b1;
                end
            end
            RUN: begin
                s_if.s_ready = 1'b1;
                busy         = 1'b1;
                vld_p0       = s_if.s_valid;
                if (vld_p0) begin
                    cov_p0[s_if.s_vec] = 1'b1;
                    if (s_if.s_resp != golden[s_if.s_vec]) begin
                        mism_p0 = 1'b1;
                        cnt_p0  = sat_inc(mismatch_cnt);
                    end
                    if (s_if.s_last) begin
                        state_nxt = DONE;
                    end
`ifdef VRC_STOP_ON_FAIL_EN
                    if (mism_p0) begin
                        state_nxt = DONE;
                    end
`else
`endif
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                    clear_p0  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        pass_p0 = (cnt_p0 == '0) && (&cov_p0);
    end

    // Stage p1: registered results, visible the cycle after the transfer
    always_ff @(posedge CK) begin
        if (!reset) begin
            state            <= IDLE;
            golden           <= '0;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            coverage         <= '0;
        end else begin
            state <= state_nxt;

            if ((state == IDLE) && cfg_we) begin
                golden[cfg_addr] <= cfg_data;
            end

            if (clear_p0) begin
                mismatch_cnt     <= '0;
                coverage         <= '0;
                first_fail_valid <= 1'b0;
                first_fail_vec   <= '0;
                pass             <= 1'b0;
            end else if (vld_p0) begin
                mismatch_cnt <= cnt_p0;
                coverage     <= cov_p0;
                if (mism_p0 && !first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec   <= s_if.s_vec;
                end
            end

            if ((state == RUN) && (state_nxt == DONE)) begin
                pass <= pass_p0;
            end
        end
    end
endmodule

// File: tb/tb_vec_resp_checker.sv
// Scoreboard bench for vec_resp_checker: expected run verdicts are queued by the stimulus
// and checked by a monitor whenever done rises.
module tb_vec_resp_checker;
    logic       CK;
    logic       reset;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic       cfg_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] mismatch_cnt;
    logic       first_fail_valid;
    logic [1:0] first_fail_vec;
    logic [3:0] coverage;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       pass;
        logic [3:0] cnt;
        logic       ffv;
        logic [1:0] ffvec;
        logic [3:0] cov;
    } exp_t;

    exp_t sb[$];

    vec_resp_checker_if #(.N_IN(2)) s_if ();

    vec_resp_checker #(.N_IN(2), .CNT_W(4)) dut (
        .CK               (CK),
        .reset            (reset),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_data         (cfg_data),
        .start            (start),
        .s_if             (s_if),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .mismatch_cnt     (mismatch_cnt),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec),
        .coverage         (coverage)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic monitor();
        logic done_q;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge CK);
            if (done === 1'b1 && done_q !== 1'b1) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("run_pass", {31'd0, pass}, {31'd0, e.pass});
                    check("run_mismatch_cnt", {28'd0, mismatch_cnt}, {28'd0, e.cnt});
                    check("run_first_fail_valid", {31'd0, first_fail_valid}, {31'd0, e.ffv});
                    if (e.ffv) begin
                        check("run_first_fail_vec", {30'd0, first_fail_vec}, {30'd0, e.ffvec});
                    end
                    check("run_coverage", {28'd0, coverage}, {28'd0, e.cov});
                end
            end
            done_q = done;
        end
    endtask

    task automatic push(input logic p, input logic [3:0] c, input logic f, input logic [1:0] fv,
                        input logic [3:0] cv);
        exp_t e;
        e.pass = p; e.cnt = c; e.ffv = f; e.ffvec = fv; e.cov = cv;
        sb.push_back(e);
    endtask

    task automatic load_golden(input logic [3:0] tbl);
        for (int a = 0; a < 4; a++) begin
            cfg_we   = 1'b1;
            cfg_addr = 2'(a);
            cfg_data = tbl[a];
            tick();
        end
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One cycle per pair; a pair presented while s_ready=0 is simply not taken.
    task automatic send(input logic [1:0] v, input logic r, input logic l);
        s_if.s_valid = 1'b1;
        s_if.s_vec   = v;
        s_if.s_resp  = r;
        s_if.s_last  = l;
        tick();
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
    endtask

    task automatic idle_cycle(input logic l);
        s_if.s_valid = 1'b0;
        s_if.s_last  = l;
        s_if.s_vec   = 2'b11;
        s_if.s_resp  = 1'b1;
        tick();
        s_if.s_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 10; i++) begin
            if (done === 1'b1) break;
            tick();
        end
        if (i == 10) check(name, 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        reset        = 1'b0;
        cfg_we       = 1'b0;
        cfg_addr     = 2'b00;
        cfg_data     = 1'b0;
        start        = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_vec   = 2'b00;
        s_if.s_resp  = 1'b0;
        s_if.s_last  = 1'b0;
        fork
            monitor();
        join_none

        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_s_ready", {31'd0, s_if.s_ready}, 32'd0);
        check("rst_cnt", {28'd0, mismatch_cnt}, 32'd0);
        check("rst_cov", {28'd0, coverage}, 32'd0);
        reset = 1'b1;
        tick();

        // All-correct full sweep
        load_golden(4'b0110);
        push(1'b1, 4'd0, 1'b0, 2'b00, 4'b1111);
        do_start();
        check("run_busy", {31'd0, busy}, 32'd1);
        send(2'b00, 1'b0, 1'b0);
        send(2'b01, 1'b1, 1'b0);
        send(2'b10, 1'b1, 1'b0);
        send(2'b11, 1'b0, 1'b1);
        wait_done("t1_done_timeout");

        // All-zero responses: 01 and 10 mismatch
`ifdef VRC_STOP_ON_FAIL_EN
        push(1'b0, 4'd1, 1'b1, 2'b01, 4'b0011);
`else
        push(1'b0, 4'd2, 1'b1, 2'b01, 4'b1111);
`endif
        do_start();
        send(2'b00, 1'b0, 1'b0);
        send(2'b01, 1'b0, 1'b0);
        check("lat1_cnt", {28'd0, mismatch_cnt}, 32'd1);
        check("lat1_ffv", {31'd0, first_fail_valid}, 32'd1);
        send(2'b10, 1'b0, 1'b0);
        send(2'b11, 1'b0, 1'b1);
        wait_done("t2_done_timeout");

        // Restart from DONE clears results; 10 skipped
        push(1'b0, 4'd0, 1'b0, 2'b00, 4'b1011);
        do_start();
        check("restart_busy", {31'd0, busy}, 32'd1);
        check("restart_cnt", {28'd0, mismatch_cnt}, 32'd0);
        check("restart_ffv", {31'd0, first_fail_valid}, 32'd0);
        check("restart_cov", {28'd0, coverage}, 32'd0);
        send(2'b00, 1'b0, 1'b0);
        send(2'b01, 1'b1, 1'b0);
        send(2'b11, 1'b0, 1'b1);
        wait_done("t3_done_timeout");

        // Gapped valid with s_last on idle cycles having no effect
`ifdef VRC_STOP_ON_FAIL_EN
        push(1'b0, 4'd1, 1'b1, 2'b00, 4'b0001);
`else
        push(1'b0, 4'd2, 1'b1, 2'b00, 4'b0001);
`endif
        do_start();
        send(2'b00, 1'b1, 1'b0);
        idle_cycle(1'b1);
        idle_cycle(1'b1);
`ifndef VRC_STOP_ON_FAIL_EN
        check("gap_busy", {31'd0, busy}, 32'd1);
`endif
        send(2'b00, 1'b1, 1'b1);
        wait_done("t4_done_timeout");

        // Counter saturation: 64 mismatching pairs
`ifdef VRC_STOP_ON_FAIL_EN
        push(1'b0, 4'd1, 1'b1, 2'b01, 4'b0010);
`else
        push(1'b0, 4'd15, 1'b1, 2'b01, 4'b0010);
`endif
        do_start();
        for (int i = 0; i < 64; i++) begin
            send(2'b01, 1'b0, (i == 63) ? 1'b1 : 1'b0);
        end
        wait_done("t5_done_timeout");

        // Reset mid-run aborts and clears the golden table
        do_start();
        send(2'b00, 1'b0, 1'b0);
        send(2'b01, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_pass", {31'd0, pass}, 32'd0);
        check("mid_rst_ready", {31'd0, s_if.s_ready}, 32'd0);
        check("mid_rst_cnt", {28'd0, mismatch_cnt}, 32'd0);
        check("mid_rst_ffv", {31'd0, first_fail_valid}, 32'd0);
        check("mid_rst_ffvec", {30'd0, first_fail_vec}, 32'd0);
        check("mid_rst_cov", {28'd0, coverage}, 32'd0);
        reset = 1'b1;
        tick();

        // Same-cycle cfg_we and start in IDLE: write lands, run begins
        push(1'b1, 4'd0, 1'b0, 2'b00, 4'b1111);
        cfg_we   = 1'b1;
        cfg_addr = 2'b11;
        cfg_data = 1'b1;
        do_start();
        cfg_we = 1'b0;
        check("cfg_start_busy", {31'd0, busy}, 32'd1);
        send(2'b00, 1'b0, 1'b0);
        send(2'b01, 1'b0, 1'b0);
        send(2'b10, 1'b0, 1'b0);
        send(2'b11, 1'b1, 1'b1);
        wait_done("t6_done_timeout");

        // cfg_we ignored in DONE and in RUN
        cfg_we   = 1'b1;
        cfg_addr = 2'b00;
        cfg_data = 1'b1;
        tick();
        cfg_we = 1'b0;
        push(1'b1, 4'd0, 1'b0, 2'b00, 4'b1111);
        do_start();
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        send(2'b00, 1'b0, 1'b0);
        check("cfg_run_ignored_cnt", {28'd0, mismatch_cnt}, 32'd0);
        send(2'b01, 1'b0, 1'b0);
        send(2'b10, 1'b0, 1'b0);
        send(2'b11, 1'b1, 1'b1);
        wait_done("t7_done_timeout");

        tick();
        tick();
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
